// File: rtl/fsm_seq_pkg.sv
// Package: fsm_seq_pkg
// Elaboration-time helpers for the serial sequence detector.
//  state_w    : width of the matched-prefix state vector for a given pattern length
//  next_state : longest pattern prefix that is a suffix of (matched prefix ++ bit)
//  fallback   : longest proper prefix of the pattern that is also a suffix of it
// Patterns are passed zero-extended to MaxPatLen bits; bit len-1 is the first expected bit.
package fsm_seq_pkg;

  localparam int unsigned MaxPatLen = 16;

  typedef logic [MaxPatLen-1:0] pat_t;

  function automatic int unsigned state_w(input int unsigned len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

  // Bit select with a narrow index so the selects stay width-clean.
  function automatic logic pat_bit(input pat_t pattern, input int unsigned idx);
    logic [3:0] ix;
    ix = idx[3:0];
    return pattern[ix];
  endfunction

  function automatic int unsigned next_state(input pat_t pattern, input int unsigned len,
                                             input int unsigned st, input logic b);
    int unsigned best;
    int unsigned pos;
    logic        ok;
    logic        sb;
    best = 0;
    for (int unsigned k = 1; k <= MaxPatLen; k++) begin
      if ((k <= st + 1) && (k <= len)) begin
        ok = 1'b1;
        for (int unsigned j = 0; j < MaxPatLen; j++) begin
          if (j < k) begin
            // Observed sequence is pattern[len-1 .. len-st] followed by b.
            pos = st + 1 - k + j;
            sb  = (pos == st) ? b : pat_bit(pattern, len - 1 - pos);
            if (sb != pat_bit(pattern, len - 1 - j)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  function automatic int unsigned fallback(input pat_t pattern, input int unsigned len);
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned k = 1; k < MaxPatLen; k++) begin
      if (k < len) begin
        ok = 1'b1;
        for (int unsigned j = 0; j < MaxPatLen; j++) begin
          if (j < k) begin
            if (pat_bit(pattern, len - 1 - j) != pat_bit(pattern, k - 1 - j)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/fsm_seq_timer.sv
// Module: fsm_seq_timer
// Progress watchdog for fsm_seq_detect (only instantiated with FSM_SEQ_TIMEOUT_EN).
// Counts cycles without prefix progress; expired_o is high while the count sits at TIMEOUT-1,
// and the count clears on the following edge.
//  Clock     in  clock, posedge
//  Reset     in  synchronous active-high reset
//  clear_i   in  restart the count (state is 0 or the prefix grew this cycle)
//  expired_o out count has reached TIMEOUT-1
module fsm_seq_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [TW-1:0] timer_q, timer_d;

  assign expired_o = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    timer_d = timer_q + TW'(1);
    if (clear_i || expired_o) timer_d = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

endmodule

// File: rtl/fsm_seq_detect.sv
// Module: fsm_seq_detect
// Serial pattern detector with partial-match fallback (KMP-style next-state table built at
// elaboration). MSB of PATTERN is the first expected bit.
//  Clock    in  clock, posedge
//  Reset    in  synchronous active-high reset
//  en       in  sample-valid qualifier for A
//  A        in  serial data bit
//  K1       out registered 1-cycle pulse on a full match
//  K2       out registered level, state == PAT_LEN-1
//  state    out matched-prefix length
//  hit_cnt  out saturating match count
//  timeout  out registered pulse when the watchdog forces state to 0
// Optional feature macro: FSM_SEQ_TIMEOUT_EN adds the watchdog and the timeout port.
module fsm_seq_detect
  import fsm_seq_pkg::*;
#(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8,
  parameter int unsigned        TIMEOUT = 16
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       en,
  input  logic                       A,
  output logic                       K1,
  output logic                       K2,
  output logic [state_w(PAT_LEN)-1:0] state,
  output logic [CNT_W-1:0]           hit_cnt
`ifdef FSM_SEQ_TIMEOUT_EN
  ,
  output logic                       timeout
`endif
);

  localparam int unsigned SW     = state_w(PAT_LEN);
  localparam int unsigned NumSt  = 2 ** SW;
  localparam pat_t        PatExt = 16'(PATTERN);
  localparam int unsigned Fb     = fallback(PatExt, PAT_LEN);

  typedef logic [SW-1:0] state_t;
  typedef logic [SW:0]   len_t;   // holds 0..PAT_LEN, where PAT_LEN means full match

  state_t           state_q, state_d;
  logic             k1_q, k1_d;
  logic             k2_q;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  len_t             n;
  logic             match;
  logic             progress;
  logic             expired;

  // Unreachable rows (state >= PAT_LEN) map to 0.
  len_t nxt_tbl [NumSt][2];
  for (genvar s = 0; s < NumSt; s++) begin : g_st
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int unsigned N = (s < PAT_LEN) ? next_state(PatExt, PAT_LEN, s, 1'(b)) : 0;
      assign nxt_tbl[s][b] = len_t'(N);
    end
  end

  always_comb begin
    n = len_t'(state_q);
    if (en) n = nxt_tbl[state_q][A];
    match    = en && (n == len_t'(PAT_LEN));
    progress = en && !match && (n > len_t'(state_q));

    state_d   = state_q;
    k1_d      = 1'b0;
    hit_cnt_d = hit_cnt_q;
    if (match) begin
      k1_d    = 1'b1;
      state_d = OVERLAP ? state_t'(Fb) : '0;
      if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end else if (en) begin
      state_d = state_t'(n);
    end
    // A full match on the expiry edge wins over the forced return.
    if (expired && !match) state_d = '0;
  end

`ifdef FSM_SEQ_TIMEOUT_EN
  logic timeout_q;

  fsm_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .Clock     (Clock),
    .Reset     (Reset),
    .clear_i   ((state_q == '0) || progress),
    .expired_o (expired)
  );

  always_ff @(posedge Clock) begin
    if (Reset) timeout_q <= 1'b0;
    else       timeout_q <= expired && !match;
  end

  assign timeout = timeout_q;
`else
  assign expired = 1'b0;
  logic unused_progress;
  assign unused_progress = progress;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= '0;
      k1_q      <= 1'b0;
      k2_q      <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      k1_q      <= k1_d;
      k2_q      <= (state_d == state_t'(PAT_LEN - 1));
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign state   = state_q;
  assign K1      = k1_q;
  assign K2      = k2_q;
  assign hit_cnt = hit_cnt_q;

endmodule
